// File: rtl/spi_pkg.sv
// spi_pkg: shared state/mode types and capture-edge selection for the SPI slave core
package spi_pkg;
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT} state_t;
    typedef enum logic [1:0] {MODE0, MODE1, MODE2, MODE3} mode_t;
    localparam logic EDGE_RISE = 1'b0;
    localparam logic EDGE_FALL = 1'b1;
    function automatic logic cap_edge(input mode_t m);
        return (m == MODE1 || m == MODE2) ? EDGE_FALL : EDGE_RISE;
    endfunction
endpackage

// File: rtl/spi_sync.sv
// spi_sync: STAGES-deep synchroniser; edges are detected between the last two stages
module spi_sync #(
    parameter int   STAGES = 2,
    parameter logic INIT   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);
    logic [STAGES-1:0] sync;
    // shift the asynchronous input through the flop chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync <= {STAGES{INIT}};
        else sync <= {sync[STAGES-2:0], d};
    end
    assign q    = sync[STAGES-1];
    assign rise = sync[STAGES-2] & ~sync[STAGES-1];
    assign fall = ~sync[STAGES-2] & sync[STAGES-1];
endmodule

// File: rtl/spi_slave_core.sv
// spi_slave_core: SPI slave, modes 0-3, back-to-back words; SPI_SLAVE_STATUS_EN adds sticky status flags
module spi_slave_core
    import spi_pkg::*;
#(
    parameter int              DATA_W      = 8,
    parameter int              SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] TX_IDLE   = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              spi_clk,
    input  logic              spi_ss,
    input  logic              spi_mosi,
    output logic              spi_miso,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy
`ifdef SPI_SLAVE_STATUS_EN
    ,
    input  logic              status_clr,
    output logic              tx_underrun,
    output logic              frame_abort
`endif
);
    localparam int CW = $clog2(DATA_W + 1);
    localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);
    state_t state, state_nx;
    mode_t mode;
    logic sclk_rise, sclk_fall, ss_rise, ss_fall, mosi;
    logic sclk_unused, ss_unused, mosi_rise_unused, mosi_fall_unused;
    logic live, cap, shf, word_end, load_en;
    logic [CW-1:0] cnt;
    logic [DATA_W-1:0] tx_sr, rx_sr;

    spi_sync #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_sclk (
        .clk(clk), .rst_n(rst_n), .d(spi_clk), .q(sclk_unused), .rise(sclk_rise), .fall(sclk_fall));
    spi_sync #(.STAGES(SYNC_STAGES), .INIT(1'b1)) u_ss (
        .clk(clk), .rst_n(rst_n), .d(spi_ss), .q(ss_unused), .rise(ss_rise), .fall(ss_fall));
    spi_sync #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_mosi (
        .clk(clk), .rst_n(rst_n), .d(spi_mosi), .q(mosi), .rise(mosi_rise_unused), .fall(mosi_fall_unused));

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else state <= state_nx;
    end

    // ss rise aborts from anywhere; ss fall opens a frame; LOAD lasts one cycle
    always_comb begin
        state_nx = ss_rise ? S_IDLE :
                   (state == S_IDLE && ss_fall) ? S_LOAD :
                   (state == S_LOAD) ? S_SHIFT : state;
    end

    // decode state and latched mode into datapath strobes
    always_comb begin
        busy     = state != S_IDLE;
        live     = state == S_SHIFT && !ss_rise;
        cap      = live && (cap_edge(mode) == EDGE_FALL ? sclk_fall : sclk_rise);
        shf      = live && (cap_edge(mode) == EDGE_FALL ? sclk_rise : sclk_fall);
        word_end = cap && cnt == LAST;
        load_en  = state == S_LOAD || word_end;
    end

    // latch the bus mode once per frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mode <= MODE0;
        else if (state == S_LOAD) mode <= mode_t'({cpol, cpha});
    end

    // TX shifter: the first shift edge after a (re)load keeps the MSB on the wire
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tx_sr <= '0;
        else if (load_en) tx_sr <= tx_valid ? tx_data : TX_IDLE;
        else if (shf && cnt != '0) tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
    end

    // RX shifter and bit counter, counter wraps at each word boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            rx_sr <= '0;
        end else begin
            cnt <= !live ? '0 : cap ? (word_end ? '0 : cnt + 1'b1) : cnt;
            if (cap) rx_sr <= {rx_sr[DATA_W-2:0], mosi};
        end
    end

    // handshake strobes and received word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data  <= '0;
            rx_valid <= 1'b0;
            tx_ready <= 1'b0;
        end else begin
            rx_valid <= word_end;
            tx_ready <= load_en && tx_valid;
            if (word_end) rx_data <= {rx_sr[DATA_W-2:0], mosi};
        end
    end

    assign spi_miso = busy ? tx_sr[DATA_W-1] : 1'bz;

`ifdef SPI_SLAVE_STATUS_EN
    // sticky flags: idle word sent, or frame closed mid-word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_underrun <= 1'b0;
            frame_abort <= 1'b0;
        end else if (status_clr) begin
            tx_underrun <= 1'b0;
            frame_abort <= 1'b0;
        end else begin
            if (load_en && !tx_valid) tx_underrun <= 1'b1;
            if (ss_rise && state == S_SHIFT && cnt != '0) frame_abort <= 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_spi_slave_core.sv
// tb_spi_slave_core: directed bench for spi_slave_core acting as SPI master and TX source
`timescale 1ns/1ps
module tb_spi_slave_core;
    logic clk = 1'b0, rst_n = 1'b1, cpol = 1'b0, cpha = 1'b0, sclk = 1'b0, ss = 1'b1, mosi = 1'b0;
    wire miso;
    pullup (miso);
    logic [7:0] tx_data, rx_data, mi, mi1;
    logic tx_valid, tx_ready, rx_valid, busy;
    logic [7:0] tx_words [4];
    logic [7:0] rx_log [4];
    int tx_taken = 0, tx_limit = 0, rx_seen = 0, t0 = 0, r0 = 0;
    int vec = 0, bad = 0;
`ifdef SPI_SLAVE_STATUS_EN
    logic status_clr = 1'b0, tx_underrun, frame_abort;
`endif

    spi_slave_core #(.DATA_W(8), .SYNC_STAGES(2), .TX_IDLE(8'hFF)) dut (
        .clk(clk), .rst_n(rst_n), .cpol(cpol), .cpha(cpha),
        .spi_clk(sclk), .spi_ss(ss), .spi_mosi(mosi), .spi_miso(miso),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy)
`ifdef SPI_SLAVE_STATUS_EN
        , .status_clr(status_clr), .tx_underrun(tx_underrun), .frame_abort(frame_abort)
`endif
    );

    always #5 clk = ~clk;

    assign tx_valid = tx_taken < tx_limit;
    assign tx_data  = tx_words[2'(tx_taken)];

    always @(negedge clk) begin
        if (tx_ready) tx_taken <= tx_taken + 1;
        if (rx_valid) begin
            rx_log[2'(rx_seen)] <= rx_data;
            rx_seen <= rx_seen + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic hp();
        repeat (8) @(negedge clk);
    endtask

    task automatic load_tx(input int n, input logic [7:0] a, input logic [7:0] b);
        tx_words[2'(tx_taken)] = a;
        tx_words[2'(tx_taken + 1)] = b;
        tx_limit = tx_taken + n;
        t0 = tx_taken;
        r0 = rx_seen;
    endtask

    task automatic start(input logic [1:0] m);
        cpol = m[1];
        cpha = m[0];
        sclk = m[1];
        hp();
        ss = 1'b0;
        hp();
    endtask

    task automatic stop();
        hp();
        ss = 1'b1;
        hp();
        hp();
    endtask

    task automatic word(input logic [7:0] mo, input int n, output logic [7:0] got);
        got = '0;
        for (int i = 7; i >= 8 - n; i--) begin
            if (!cpha) begin
                mosi = mo[i];
                hp();
                got[i] = miso;
                sclk = ~cpol;
                hp();
                sclk = cpol;
            end else begin
                sclk = ~cpol;
                mosi = mo[i];
                hp();
                got[i] = miso;
                sclk = cpol;
                hp();
            end
        end
    endtask

`ifdef SPI_SLAVE_STATUS_EN
    task automatic clr_status();
        status_clr = 1'b1;
        @(negedge clk);
        status_clr = 1'b0;
        @(negedge clk);
    endtask
`endif

    initial begin
        for (int i = 0; i < 4; i++) tx_words[i] = '0;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_rxv", 32'(rx_valid), 0);
        check("rst_txr", 32'(tx_ready), 0);
        check("rst_rxd", 32'(rx_data), 0);
        check("rst_miso_z", 32'(miso), 1);
        rst_n = 1'b1;
        hp();

        load_tx(1, 8'h3C, 8'h00);
        start(2'b00);
        word(8'hA5, 8, mi);
        stop();
        check("m0_rx", 32'(rx_log[2'(r0)]), 32'hA5);
        check("m0_rxv", rx_seen - r0, 1);
        check("m0_miso", 32'(mi), 32'h3C);
        check("m0_txr", tx_taken - t0, 1);

        for (int m = 1; m < 4; m++) begin
            load_tx(1, 8'hC3, 8'h00);
            start(m[1:0]);
            word(8'h5A, 8, mi);
            stop();
            check($sformatf("m%0d_rx", m), 32'(rx_log[2'(r0)]), 32'h5A);
            check($sformatf("m%0d_rxv", m), rx_seen - r0, 1);
            check($sformatf("m%0d_miso", m), 32'(mi), 32'hC3);
        end

        load_tx(2, 8'h11, 8'h22);
        start(2'b00);
        word(8'h96, 8, mi1);
        word(8'h69, 8, mi);
        stop();
        check("b2b_rxv", rx_seen - r0, 2);
        check("b2b_rx0", 32'(rx_log[2'(r0)]), 32'h96);
        check("b2b_rx1", 32'(rx_log[2'(r0 + 1)]), 32'h69);
        check("b2b_miso0", 32'(mi1), 32'h11);
        check("b2b_miso1", 32'(mi), 32'h22);
        check("b2b_txr", tx_taken - t0, 2);

`ifdef SPI_SLAVE_STATUS_EN
        clr_status();
        check("und_pre", 32'(tx_underrun), 0);
`endif
        load_tx(0, 8'h00, 8'h00);
        start(2'b00);
        word(8'h33, 8, mi);
        stop();
        check("und_miso", 32'(mi), 32'hFF);
        check("und_txr", tx_taken - t0, 0);
        check("und_rx", 32'(rx_log[2'(r0)]), 32'h33);
`ifdef SPI_SLAVE_STATUS_EN
        check("und_flag", 32'(tx_underrun), 1);
        clr_status();
        check("und_clr", 32'(tx_underrun), 0);
        check("abt_pre", 32'(frame_abort), 0);
`endif

        load_tx(1, 8'h77, 8'h00);
        start(2'b00);
        word(8'hF0, 5, mi);
        stop();
        check("abt_rxv", rx_seen - r0, 0);
        check("abt_txr", tx_taken - t0, 1);
        check("abt_miso", 32'(mi), 32'h70);
`ifdef SPI_SLAVE_STATUS_EN
        check("abt_flag", 32'(frame_abort), 1);
`endif
        load_tx(1, 8'h5C, 8'h00);
        start(2'b00);
        word(8'h81, 8, mi);
        stop();
        check("post_abt_rx", 32'(rx_log[2'(r0)]), 32'h81);
        check("post_abt_rxv", rx_seen - r0, 1);
        check("post_abt_miso", 32'(mi), 32'h5C);

        load_tx(1, 8'hE7, 8'h00);
        start(2'b00);
        word(8'hFF, 4, mi);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_busy", 32'(busy), 0);
        check("mid_rxv", 32'(rx_valid), 0);
        check("mid_txr", 32'(tx_ready), 0);
        check("mid_rxd", 32'(rx_data), 0);
        check("mid_miso_z", 32'(miso), 1);
        ss = 1'b1;
        sclk = 1'b0;
        hp();
        rst_n = 1'b1;
        hp();
        load_tx(1, 8'h24, 8'h00);
        start(2'b00);
        word(8'h42, 8, mi);
        stop();
        check("post_rst_rx", 32'(rx_log[2'(r0)]), 32'h42);
        check("post_rst_rxv", rx_seen - r0, 1);
        check("post_rst_miso", 32'(mi), 32'h24);

        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end
endmodule
